counter_arbiter: RTL and testbench

Round-robin scheduler that shares one internal WIDTH-bit up-counter among N_REQ requesters. Each requester asks for a timed interval of `len` clock cycles; the arbiter grants the counter to one requester at a time, runs it from 0 to len-1, pulses that requester's `done`, then services the next requester. It sits between counter clients and the counter datapath, owning the counter's clear and enable.

---
 rtl/counter_arbiter.sv | 149 ++++++++++++++
 tb/tb_counter_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin scheduler sharing one WIDTH-bit up-counter among N_REQ
//   requesters. The winner's length is latched at grant time. The counter then
//   runs from 0 to len-1, and a one-cycle done pulse is returned to the owner.
//   The next arbitration happens one IDLE cycle later.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   req    : per-requester request level, held until done or abandoned
//   len    : packed interval lengths, requester i at [i*WIDTH +: WIDTH]
//   grant  : one-hot current owner of the counter (all-zero when none)
//   value  : current counter value
//   busy   : high while an interval is running or completing
//   done   : one-cycle completion pulse to the owning requester
module counter_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   len,
  output logic [N_REQ-1:0]         grant,
  output logic [WIDTH-1:0]         value,
  output logic                     busy,
  output logic [N_REQ-1:0]         done
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic [WIDTH-1:0]   len_q;
  logic [WIDTH-1:0]   value_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [WIDTH-1:0]   win_len;
  logic [IDX_W-1:0]   cand;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: the first requester found starting at last_grant+1
  // and wrapping around the requester set wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Length of the winning requester, taken only while arbitrating.
  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_len = len[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      len_q   <= '0;
      value_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            owner_q <= win_idx;
            len_q   <= win_len;
            value_q <= '0;
            busy_q  <= 1'b1;
            if (win_len != '0) begin
              state_q <= S_RUN;
              grant_q <= onehot(win_idx);
            end else begin
              // Zero-length interval: straight to completion, no RUN cycles.
              state_q <= S_DONE;
              grant_q <= '0;
              done_q  <= onehot(win_idx);
            end
          end
        end
        S_RUN: begin
          if (!req[owner_q]) begin
            // Abandoned by owner: no done pulse, value frozen, rotate past it.
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end else if (value_q == len_q - ONE) begin
            state_q <= S_DONE;
            grant_q <= '0;
            done_q  <= onehot(owner_q);
          end else begin
            value_q <= value_q + ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign value = value_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [WIDTH-1:0]       value;
  logic                   busy;
  logic [N_REQ-1:0]       done;

  int tests  = 0;
  int failed = 0;

  counter_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .value (value),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [7:0] v);
    chk($sformatf("%s.grant", tag), 32'(grant), 32'(g));
    chk($sformatf("%s.done",  tag), 32'(done),  32'(d));
    chk($sformatf("%s.busy",  tag), 32'(busy),  32'(b));
    chk($sformatf("%s.value", tag), 32'(value), 32'(v));
  endtask

  task automatic set_len(input int unsigned i, input logic [7:0] l);
    len[i*WIDTH +: WIDTH] = l;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    len   = '0;

    // Reset held, then released
    step();
    step();
    chk_out("rst_hold", 4'b0000, 4'b0000, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_out("rst_rel", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Single request, len0=3
    req = 4'b0001;
    set_len(0, 8'd3);
    step(); chk_out("single.v0", 4'b0001, 4'b0000, 1'b1, 8'd0);
    step(); chk_out("single.v1", 4'b0001, 4'b0000, 1'b1, 8'd1);
    step(); chk_out("single.v2", 4'b0001, 4'b0000, 1'b1, 8'd2);
    step(); chk_out("single.done", 4'b0000, 4'b0001, 1'b1, 8'd2);
    req = 4'b0000;
    step(); chk_out("single.idle", 4'b0000, 4'b0000, 1'b0, 8'd2);

    // Simultaneous requests 1 and 2
    req = 4'b0110;
    set_len(1, 8'd2);
    set_len(2, 8'd1);
    step(); chk_out("simul.r1v0", 4'b0010, 4'b0000, 1'b1, 8'd0);
    step(); chk_out("simul.r1v1", 4'b0010, 4'b0000, 1'b1, 8'd1);
    step(); chk_out("simul.r1done", 4'b0000, 4'b0010, 1'b1, 8'd1);
    req = 4'b0100;
    step(); chk_out("simul.idle", 4'b0000, 4'b0000, 1'b0, 8'd1);
    step(); chk_out("simul.r2v0", 4'b0100, 4'b0000, 1'b1, 8'd0);
    step(); chk_out("simul.r2done", 4'b0000, 4'b0100, 1'b1, 8'd0);
    req = 4'b0000;
    step(); chk_out("simul.idle2", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Fairness: reset so requester 0 wins first, then all request len=1
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int unsigned i = 0; i < N_REQ; i++) set_len(i, 8'd1);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      step(); chk_out($sformatf("fair%0d.grant", k), exp_g, 4'b0000, 1'b1, 8'd0);
      step(); chk_out($sformatf("fair%0d.done", k), 4'b0000, exp_g, 1'b1, 8'd0);
      if (k == 5) req = 4'b0000;
      step(); chk_out($sformatf("fair%0d.idle", k), 4'b0000, 4'b0000, 1'b0, 8'd0);
    end

    // Zero length on requester 0
    req = 4'b0001;
    set_len(0, 8'd0);
    step(); chk_out("zero.done", 4'b0000, 4'b0001, 1'b1, 8'd0);
    req = 4'b0000;
    step(); chk_out("zero.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Abort at value 4
    req = 4'b0001;
    set_len(0, 8'd10);
    step(); chk_out("abort.v0", 4'b0001, 4'b0000, 1'b1, 8'd0);
    step(); step(); step(); step();
    chk_out("abort.v4", 4'b0001, 4'b0000, 1'b1, 8'd4);
    req = 4'b0000;
    step(); chk_out("abort.idle", 4'b0000, 4'b0000, 1'b0, 8'd4);
    step(); chk_out("abort.nodone", 4'b0000, 4'b0000, 1'b0, 8'd4);
    req = 4'b0011;
    set_len(1, 8'd1);
    step(); chk_out("abort.r1", 4'b0010, 4'b0000, 1'b1, 8'd0);
    step(); chk_out("abort.r1done", 4'b0000, 4'b0010, 1'b1, 8'd0);
    req = 4'b0000;
    step(); chk_out("abort.idle2", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Reset in the middle of a long run
    req = 4'b0001;
    set_len(0, 8'd200);
    step(); chk_out("midrst.v0", 4'b0001, 4'b0000, 1'b1, 8'd0);
    for (int i = 0; i < 50; i++) step();
    chk_out("midrst.v50", 4'b0001, 4'b0000, 1'b1, 8'd50);
    reset = 1'b0;
    #1;
    chk_out("midrst.async", 4'b0000, 4'b0000, 1'b0, 8'd0);
    step(); chk_out("midrst.held", 4'b0000, 4'b0000, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    step(); chk_out("midrst.regrant", 4'b0001, 4'b0000, 1'b1, 8'd0);
    step(); chk_out("midrst.v1", 4'b0001, 4'b0000, 1'b1, 8'd1);
    req = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
